stopwatch_display_scan: RTL

// Downstream of the stopwatch counters. Multiplexes the four BCD digits (M.SS.t) onto the
// 8-anode, 7-segment display, one digit at a time, at a divided refresh rate. Input digits
// are snapshotted once per scan frame so a frame never mixes old and new values. When the
// 5-minute limit flag is set, all digits blink.

---
 rtl/stopwatch_display_scan.sv | 111 +++++++++++
 1 files changed

// File: rtl/stopwatch_display_scan.sv
// Scans the four stopwatch BCD digits (M.SS.t) onto an 8-anode 7-segment display.
// Digits are snapshotted per frame; all digits blink while the limit flag is held.
module stopwatch_display_scan #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic       CLK,
    input  logic       SCLR_N,
    input  logic [3:0] TENTHS,
    input  logic [3:0] SECONDS,
    input  logic [3:0] TENS_SECONDS,
    input  logic [3:0] MINUTES,
    input  logic       LIMIT,
    input  logic       BLANK_LZ,
    output logic [6:0] CATHODES,
    output logic       DP_N,
    output logic [7:0] ANODES
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);

    typedef struct packed {
        logic       limit;
        logic [3:0] m;
        logic [3:0] ts;
        logic [3:0] s;
        logic [3:0] t;
    } snap_t;

    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [FW-1:0] frame_cnt;
    logic          blink_phase;
    snap_t         snap;
    snap_t         snap_nxt;
    logic          slot_tick;
    logic          frame_tick;
    logic          snap_load;
    logic          blank;
    logic [3:0]    digit;
    logic [6:0]    seg;

    always_comb begin
        slot_tick  = (presc == PRESC_MAX);
        frame_tick = slot_tick && (idx == 2'd3);
        snap_load  = (presc == '0) && (idx == 2'd0);
        // The loading cycle already displays the new frame's values.
        snap_nxt   = snap_load ?
            {LIMIT, MINUTES, TENS_SECONDS, SECONDS, TENTHS} : snap;
        case (idx)
            2'd0:    digit = snap_nxt.t;
            2'd1:    digit = snap_nxt.s;
            2'd2:    digit = snap_nxt.ts;
            default: digit = snap_nxt.m;
        endcase
        case (digit)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h3F;
        endcase
        blank = (snap_nxt.limit && blink_phase) ||
                ((idx == 2'd3) && BLANK_LZ && (snap_nxt.m == 4'd0));
    end

    always_ff @(posedge CLK) begin
        if (!SCLR_N) begin
            presc       <= '0;
            idx         <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            snap        <= '0;
            ANODES      <= 8'hFF;
            CATHODES    <= 7'h7F;
            DP_N        <= 1'b1;
        end else begin
            presc <= slot_tick ? '0 : presc + 1'b1;
            if (slot_tick)
                idx <= idx + 2'd1;
            if (frame_tick) begin
                if (frame_cnt == FRAME_MAX) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
            snap <= snap_nxt;
            if (blank) begin
                ANODES   <= 8'hFF;
                CATHODES <= 7'h7F;
                DP_N     <= 1'b1;
            end else begin
                ANODES   <= ~(8'b1 << idx);
                CATHODES <= seg;
                DP_N     <= ~idx[0];
            end
        end
    end

endmodule
